// File: rtl/biriq_cu_pkg.sv
// Shared types for the RV32M complex unit: opcode and state encodings plus
// the divider iteration count.
package biriq_cu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } cu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } cu_state_t;

    localparam int DIV_ITER = 32;

    // Absolute value of a 32-bit operand when it is to be treated as signed.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/complex_unit_if.sv
// Request/response bundle between the scheduler (master) and the complex unit (slave).
interface complex_unit_if;
    logic        flush_i;
    logic        cu_valid_i;
    logic [2:0]  cu_opcode_i;
    logic [31:0] cu_operand1_i;
    logic [31:0] cu_operand2_i;
    logic        busy_o;
    logic [31:0] result_o;
    logic        wb_valid_o;

    modport slave (
        input  flush_i, cu_valid_i, cu_opcode_i, cu_operand1_i, cu_operand2_i,
        output busy_o, result_o, wb_valid_o
    );

    modport master (
        output flush_i, cu_valid_i, cu_opcode_i, cu_operand1_i, cu_operand2_i,
        input  busy_o, result_o, wb_valid_o
    );
endinterface

// File: rtl/cu_divider.sv
// Radix-2 restoring divider on operand magnitudes: 32 iterations, then one
// cycle that applies the quotient/remainder signs and pulses done_o.
module cu_divider
    import biriq_cu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o
);

    logic        run_q, fix_q, done_q;
    logic        quo_neg_q, rem_neg_q;
    logic [5:0]  iter_q;
    logic [31:0] quo_q, rem_q, dsr_q;
    logic [31:0] quo_res_q, rem_res_q;

    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_d, quo_d;

    // Partial remainder stays below the divisor, so the 32-bit difference is exact.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        ge      = shifted >= {1'b0, dsr_q};
        rem_d   = ge ? (shifted[31:0] - dsr_q) : shifted[31:0];
        quo_d   = {quo_q[30:0], ge};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q     <= 1'b0;
            fix_q     <= 1'b0;
            done_q    <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            iter_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            quo_res_q <= '0;
            rem_res_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                run_q <= 1'b0;
                fix_q <= 1'b0;
            end else if (start_i) begin
                quo_q     <= magnitude(dividend_i, signed_i);
                dsr_q     <= magnitude(divisor_i, signed_i);
                rem_q     <= '0;
                iter_q    <= '0;
                run_q     <= 1'b1;
                fix_q     <= 1'b0;
                quo_neg_q <= signed_i & (dividend_i[31] ^ divisor_i[31]) & (|divisor_i);
                rem_neg_q <= signed_i & dividend_i[31];
            end else if (run_q) begin
                quo_q <= quo_d;
                rem_q <= rem_d;
                if (iter_q == 6'(DIV_ITER - 1)) begin
                    run_q <= 1'b0;
                    fix_q <= 1'b1;
                end else begin
                    iter_q <= iter_q + 6'd1;
                end
            end else if (fix_q) begin
                quo_res_q <= quo_neg_q ? (~quo_q + 32'd1) : quo_q;
                rem_res_q <= rem_neg_q ? (~rem_q + 32'd1) : rem_q;
                done_q    <= 1'b1;
                fix_q     <= 1'b0;
            end
        end
    end

    assign quotient_o  = quo_res_q;
    assign remainder_o = rem_res_q;
    assign done_o      = done_q;

endmodule

// File: rtl/complex_unit.sv
// RV32M multiply/divide unit: inline pipelined 33x33 multiplier, iterative
// divider sub-module, one-request-at-a-time control FSM.
module complex_unit
    import biriq_cu_pkg::*;
#(
    parameter int MUL_STAGES = 1
) (
    input  logic           cpu_clk_i,
    input  logic           cpu_rst_n_i,
    complex_unit_if.slave  cu
);

    // Only 1 and 2 are meaningful; anything else behaves as 1.
    localparam int PIPE = (MUL_STAGES == 2) ? 2 : 1;

    cu_state_t   state_q;
    cu_op_t      op_q;
    logic [31:0] op1_q, op2_q;
    logic [1:0]  cnt_q;
    logic        special_q;
    logic [31:0] special_res_q;
    logic [31:0] result_q;
    logic        wb_valid_q;
    logic [63:0] prod_pipe_q [PIPE];

    logic        accept;
    logic        div_sgn_in, div_zero_in, div_ovf_in, div_special_in;
    logic        a_ext, b_ext;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] mul_res, div_quo, div_rem;
    logic        div_done;

    assign accept         = (state_q == ST_IDLE) && cu.cu_valid_i && !cu.flush_i;
    assign div_sgn_in     = ~cu.cu_opcode_i[0];
    assign div_zero_in    = (cu.cu_operand2_i == 32'd0);
    assign div_ovf_in     = div_sgn_in && (cu.cu_operand1_i == 32'h8000_0000)
                            && (cu.cu_operand2_i == 32'hFFFF_FFFF);
    assign div_special_in = div_zero_in || div_ovf_in;

    // Low 64 bits of the sign-extended 33x33 product are exact.
    assign a_ext   = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && op1_q[31];
    assign b_ext   = (op_q == OP_MULH) && op2_q[31];
    assign mul_a   = {{32{a_ext}}, op1_q};
    assign mul_b   = {{32{b_ext}}, op2_q};
    assign product = mul_a * mul_b;
    assign mul_res = (op_q == OP_MUL) ? prod_pipe_q[PIPE-1][31:0] : prod_pipe_q[PIPE-1][63:32];

    for (genvar gi = 0; gi < PIPE; gi++) begin : g_mul_pipe
        if (gi == 0) begin : g_first
            always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
                if (!cpu_rst_n_i) prod_pipe_q[gi] <= '0;
                else              prod_pipe_q[gi] <= product;
            end
        end else begin : g_next
            always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
                if (!cpu_rst_n_i) prod_pipe_q[gi] <= '0;
                else              prod_pipe_q[gi] <= prod_pipe_q[gi-1];
            end
        end
    end

    cu_divider u_div (
        .clk_i       (cpu_clk_i),
        .rst_n_i     (cpu_rst_n_i),
        .flush_i     (cu.flush_i),
        .start_i     (accept && cu.cu_opcode_i[2] && !div_special_in),
        .signed_i    (div_sgn_in),
        .dividend_i  (cu.cu_operand1_i),
        .divisor_i   (cu.cu_operand2_i),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .done_o      (div_done)
    );

    always_ff @(posedge cpu_clk_i or negedge cpu_rst_n_i) begin
        if (!cpu_rst_n_i) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_MUL;
            op1_q         <= '0;
            op2_q         <= '0;
            cnt_q         <= '0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result_q      <= '0;
            wb_valid_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            if (cu.flush_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: if (cu.cu_valid_i) begin
                        op_q          <= cu_op_t'(cu.cu_opcode_i);
                        op1_q         <= cu.cu_operand1_i;
                        op2_q         <= cu.cu_operand2_i;
                        cnt_q         <= '0;
                        special_q     <= cu.cu_opcode_i[2] && div_special_in;
                        special_res_q <= div_zero_in ? (cu.cu_opcode_i[1] ? cu.cu_operand1_i : 32'hFFFF_FFFF)
                                                     : (cu.cu_opcode_i[1] ? 32'd0 : 32'h8000_0000);
                        state_q       <= cu.cu_opcode_i[2] ? ST_DIV : ST_MUL;
                    end
                    ST_MUL: begin
                        if (cnt_q == 2'(PIPE)) begin
                            result_q   <= mul_res;
                            wb_valid_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                    ST_DIV: begin
                        // Divide-by-zero and overflow finish on the multiplier's schedule.
                        if (special_q) begin
                            if (cnt_q == 2'(PIPE)) begin
                                result_q   <= special_res_q;
                                wb_valid_q <= 1'b1;
                                state_q    <= ST_DONE;
                            end else begin
                                cnt_q <= cnt_q + 2'd1;
                            end
                        end else if (div_done) begin
                            result_q   <= op_q[1] ? div_rem : div_quo;
                            wb_valid_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cu.busy_o     = (state_q != ST_IDLE);
    assign cu.result_o   = result_q;
    assign cu.wb_valid_o = wb_valid_q;

endmodule
